// File: rtl/multicycle_machine.sv
// Multicycle MIPS-subset core: FSM-sequenced fetch/decode/execute over a single
// req/ready memory port, with sticky exception, halt and perf counters.
module multicycle_machine #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             except,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_ADDM = 6'h2c;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        except_d;
  logic        retire;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] sext_imm, zext_imm;
  logic [7:0]  lbu_byte;
  logic        is_store;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};
  assign lbu_byte = 8'(mdr_q >> {alu_q[1:0], 3'b000});
  assign is_store = (op == OP_SW) || (op == OP_SB);

  function automatic logic is_valid(input logic [31:0] instr);
    logic v;
    v = 1'b0;
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_JR, F_ADDM: v = 1'b1;
          default: v = 1'b0;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_BEQ, OP_BNE, OP_J,
      OP_LW, OP_LBU, OP_SW, OP_SB: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Memory port is a decode of the current state; reset drops the request at once.
  assign mem_req   = reset && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we    = (state_q == S_MEM) && is_store;
  assign mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem_be    = ((state_q == S_MEM) && (op == OP_SB)) ? (4'b0001 << alu_q[1:0]) : 4'b1111;
  assign mem_wdata = (op == OP_SB) ? {4{b_q[7:0]}} : b_q;

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    except_d = except;
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = (op == OP_RTYPE) ? rd : rt;
    rf_wdata = alu_q;

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        a_d = rf[rs];
        b_d = rf[rt];
        if (is_valid(ir_q)) begin
          state_d = S_EXEC;
        end else begin
          state_d  = S_HALT;
          except_d = 1'b1;
        end
      end

      S_EXEC: begin
        state_d = S_WB;
        case (op)
          OP_RTYPE: begin
            case (funct)
              F_ADD: alu_d = a_q + b_q;
              F_SUB: alu_d = a_q - b_q;
              F_AND: alu_d = a_q & b_q;
              F_OR:  alu_d = a_q | b_q;
              F_XOR: alu_d = a_q ^ b_q;
              F_NOR: alu_d = ~(a_q | b_q);
              F_SLT: alu_d = {31'b0, $signed(a_q) < $signed(b_q)};
              F_JR: begin
                pc_d    = a_q;
                state_d = S_FETCH;
                retire  = 1'b1;
              end
              F_ADDM: begin
                alu_d = a_q;
                if (a_q[1:0] != 2'b00) begin
                  state_d  = S_HALT;
                  except_d = 1'b1;
                end else begin
                  state_d = S_MEM;
                end
              end
              default: begin
                state_d  = S_HALT;
                except_d = 1'b1;
              end
            endcase
          end
          OP_ADDI: alu_d = a_q + sext_imm;
          OP_SLTI: alu_d = {31'b0, $signed(a_q) < $signed(sext_imm)};
          OP_ANDI: alu_d = a_q & zext_imm;
          OP_ORI:  alu_d = a_q | zext_imm;
          OP_XORI: alu_d = a_q ^ zext_imm;
          OP_LUI:  alu_d = {imm, 16'h0000};
          OP_BEQ, OP_BNE: begin
            // pc_q already points past the branch
            if ((a_q == b_q) == (op == OP_BEQ)) begin
              pc_d = pc_q + {sext_imm[29:0], 2'b00};
            end
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_J: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_LW, OP_SW: begin
            alu_d = a_q + sext_imm;
            if (alu_d[1:0] != 2'b00) begin
              state_d  = S_HALT;
              except_d = 1'b1;
            end else begin
              state_d = S_MEM;
            end
          end
          OP_LBU, OP_SB: begin
            alu_d   = a_q + sext_imm;
            state_d = S_MEM;
          end
          default: begin
            state_d  = S_HALT;
            except_d = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        if (mem_ready) begin
          if (is_store) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        case (op)
          OP_LW:    rf_wdata = mdr_q;
          OP_LBU:   rf_wdata = {24'h000000, lbu_byte};
          OP_RTYPE: rf_wdata = (funct == F_ADDM) ? (mdr_q + b_q) : alu_q;
          default:  rf_wdata = alu_q;
        endcase
        rf_we   = (rf_waddr != 5'd0);
        state_d = S_FETCH;
        retire  = 1'b1;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  // State, datapath registers and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      except      <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      except  <= except_d;
      if (state_q != S_HALT) cycle_count <= cycle_count + CNT_W'(1);
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Register file; r0 is never written so it always reads zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

endmodule
